// File: rtl/sram_stream_port_master_pkg.sv
// sram_stream_port_master_pkg: shared state encoding and constants for the SRAM stream port master
package sram_stream_port_master_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;
  localparam logic [1023:0] WEM_ONES = '1;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_FIN} state_t;
endpackage

// File: rtl/sram_stream_port_master_if.sv
// sram_stream_port_master_if: command, write/read stream and SRAM port signals of the stream master
interface sram_stream_port_master_if #(parameter int AW = 10, parameter int DW = 32);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          sram_ce;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic          sram_we;
  logic [DW-1:0] sram_wem;
  logic [DW-1:0] sram_q;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, sram_q,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, sram_ce, sram_a, sram_d, sram_we, sram_wem
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, sram_q,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, sram_ce, sram_a, sram_d, sram_we, sram_wem
  );
endinterface

// File: rtl/sram_stream_port_master_fifo.sv
// sram_rd_skid_fifo: 2-entry read-data buffer with registered head and occupancy count
module sram_rd_skid_fifo #(parameter int DW = 32) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);
  logic [DW-1:0] mem [2];
  logic wp, rp;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  assign valid = count != 2'd0;
  assign dout  = mem[rp];
endmodule

// File: rtl/sram_stream_port_master.sv
// sram_stream_port_master: turns burst commands into per-word SRAM accesses streamed over valid/ready
module sram_stream_port_master
  import sram_stream_port_master_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic CLK,
  input logic RST,
  sram_stream_port_master_if.master bus
);
  state_t state, state_n;
  logic [AW-1:0] addr;
  logic [AW:0]   rem;
  logic          inflight, wr_fire, rd_issue, pop, last;
  logic [1:0]    count;
  assign pop  = bus.rd_valid & bus.rd_ready;
  assign last = rem == (AW+1)'(1);
  always_comb begin
    state_n  = state;
    wr_fire  = state == S_WRITE && bus.wr_valid;
    // a word still in flight will land in the buffer, so it holds a slot already
    rd_issue = state == S_READ && ({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
    case (state)
      S_IDLE:  if (bus.cmd_valid && bus.cmd_ready)
                 state_n = bus.cmd_len == '0 ? S_FIN : bus.cmd_write ? S_WRITE : S_READ;
      S_WRITE: if (wr_fire && last) state_n = S_FIN;
      S_READ:  if (rd_issue && last) state_n = S_DRAIN;
      S_DRAIN: if (count == 2'd0 && !inflight) state_n = S_FIN;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      addr     <= '0;
      rem      <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_n;
      inflight <= rd_issue;
      if (state == S_IDLE && bus.cmd_valid) begin
        addr <= bus.cmd_addr;
        rem  <= bus.cmd_len;
      end else if (wr_fire || rd_issue) begin
        addr <= addr + 1'b1;
        rem  <= rem - 1'b1;
      end
    end
  end
  sram_rd_skid_fifo #(.DW(DW)) u_fifo (
    .CLK(CLK), .RST(RST), .push(inflight), .pop(pop), .din(bus.sram_q),
    .valid(bus.rd_valid), .dout(bus.rd_data), .count(count)
  );
  assign bus.cmd_ready = state == S_IDLE && !RST;
  assign bus.wr_ready  = state == S_WRITE;
  assign bus.busy      = state != S_IDLE;
  assign bus.done      = state == S_FIN;
  assign bus.sram_ce   = wr_fire | rd_issue;
  assign bus.sram_we   = wr_fire;
  assign bus.sram_a    = (wr_fire | rd_issue) ? addr : '0;
  assign bus.sram_d    = wr_fire ? bus.wr_data : '0;
  assign bus.sram_wem  = wr_fire ? WEM_ONES[DW-1:0] : '0;
endmodule

// File: tb/tb_sram_stream_port_master.sv
// tb_sram_stream_port_master: directed vector bench with an SRAM behavioural model
module tb_sram_stream_port_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sram_stream_port_master_if #(.AW(10), .DW(32)) bus ();
  sram_stream_port_master #(.AW(10), .DW(32)) dut (.CLK(clk), .RST(rst), .bus(bus));
  logic [31:0] mem [1024];
  logic [31:0] q;
  assign bus.sram_q = q;
  always @(posedge clk)
    if (bus.sram_ce) begin
      if (bus.sram_we) mem[bus.sram_a] <= (mem[bus.sram_a] & ~bus.sram_wem) | (bus.sram_d & bus.sram_wem);
      else q <= mem[bus.sram_a];
    end
  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct {
    logic        cv, cw;
    logic [9:0]  ca;
    logic [10:0] cl;
    logic        wv;
    logic [31:0] wd;
    logic [5:0]  flags;
    logic [9:0]  a;
    logic [31:0] d;
  } vec_t;
  function automatic vec_t mv(logic cv, logic cw, logic [9:0] ca, logic [10:0] cl, logic wv,
                              logic [31:0] wd, logic [5:0] flags, logic [9:0] a, logic [31:0] d);
    vec_t v;
    v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl; v.wv = wv; v.wd = wd;
    v.flags = flags; v.a = a; v.d = d;
    return v;
  endfunction
  vec_t tbl[18];
  logic [31:0] exp_q [8];
  task automatic run_read(input logic [9:0] a, input int len, input logic [5:0] pat, input int exp_first);
    int occ, infl, nw, nd, nis, first, lastc;
    logic issue, pop;
    logic [9:0] ea;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = a; bus.cmd_len = 11'(len);
    bus.rd_ready = 1'b0; bus.wr_valid = 1'b0;
    #2 chk("rd_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    occ = 0; infl = 0; nw = 0; nd = 0; nis = 0; first = -1; lastc = -1; ea = a;
    for (int c = 1; c < 80 && nd == 0; c++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.rd_ready  = pat[(c-1)%6];
      #2;
      issue = bus.sram_ce & ~bus.sram_we;
      pop   = bus.rd_valid & bus.rd_ready;
      chk("rd_valid_occ", 32'(bus.rd_valid), 32'(occ != 0));
      if (bus.sram_we) chk("rd_no_write", 32'(bus.sram_we), 32'd0);
      if (issue) begin
        chk("rd_credit", 32'(occ + infl - int'(pop) < 2), 32'd1);
        chk("rd_addr", 32'(bus.sram_a), 32'(ea));
        ea++;
        nis++;
      end
      if (bus.rd_valid && first < 0) first = c;
      if (pop) begin
        if (nw < 8) chk("rd_data", bus.rd_data, exp_q[nw]);
        nw++;
        lastc = c;
      end
      if (bus.done) nd++;
      occ  = occ + infl - int'(pop);
      infl = int'(issue);
    end
    @(negedge clk);
    bus.rd_ready = 1'b0;
    #2;
    chk("rd_done_single", 32'(bus.done), 32'd0);
    chk("rd_idle_after", 32'(bus.cmd_ready), 32'd1);
    chk("rd_words", 32'(nw), 32'(len));
    chk("rd_done_count", 32'(nd), 32'd1);
    chk("rd_issued", 32'(nis), 32'(len));
    if (exp_first >= 0) begin
      chk("rd_first_valid", 32'(first), 32'(exp_first));
      chk("rd_back_to_back", 32'(lastc - first), 32'(len - 1));
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5500_0000 | 32'(i);
    q = '0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b1;
    tbl[0]  = mv(1, 1, 10'h3F0, 11'd4, 1, 32'hDEAD, 6'b100000, 10'h000, 32'h0);
    tbl[1]  = mv(0, 0, 10'h000, 11'd0, 1, 32'hA0,   6'b011011, 10'h3F0, 32'hA0);
    tbl[2]  = mv(0, 0, 10'h000, 11'd0, 1, 32'hA1,   6'b011011, 10'h3F1, 32'hA1);
    tbl[3]  = mv(0, 0, 10'h000, 11'd0, 1, 32'hA2,   6'b011011, 10'h3F2, 32'hA2);
    tbl[4]  = mv(0, 0, 10'h000, 11'd0, 1, 32'hA3,   6'b011011, 10'h3F3, 32'hA3);
    tbl[5]  = mv(0, 0, 10'h000, 11'd0, 1, 32'hBEEF, 6'b001100, 10'h000, 32'h0);
    tbl[6]  = mv(0, 0, 10'h000, 11'd0, 0, 32'h0,    6'b100000, 10'h000, 32'h0);
    tbl[7]  = mv(1, 0, 10'h100, 11'd0, 0, 32'h0,    6'b100000, 10'h000, 32'h0);
    tbl[8]  = mv(0, 0, 10'h000, 11'd0, 0, 32'h0,    6'b001100, 10'h000, 32'h0);
    tbl[9]  = mv(0, 0, 10'h000, 11'd0, 0, 32'h0,    6'b100000, 10'h000, 32'h0);
    tbl[10] = mv(1, 1, 10'h3FE, 11'd4, 0, 32'h0,    6'b100000, 10'h000, 32'h0);
    tbl[11] = mv(0, 0, 10'h000, 11'd0, 1, 32'hB0,   6'b011011, 10'h3FE, 32'hB0);
    tbl[12] = mv(0, 0, 10'h000, 11'd0, 1, 32'hB1,   6'b011011, 10'h3FF, 32'hB1);
    tbl[13] = mv(0, 0, 10'h000, 11'd0, 0, 32'hCC,   6'b011000, 10'h000, 32'h0);
    tbl[14] = mv(0, 0, 10'h000, 11'd0, 1, 32'hB2,   6'b011011, 10'h000, 32'hB2);
    tbl[15] = mv(0, 0, 10'h000, 11'd0, 1, 32'hB3,   6'b011011, 10'h001, 32'hB3);
    tbl[16] = mv(0, 0, 10'h000, 11'd0, 0, 32'h0,    6'b001100, 10'h000, 32'h0);
    tbl[17] = mv(0, 0, 10'h000, 11'd0, 0, 32'h0,    6'b100000, 10'h000, 32'h0);
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ce", 32'(bus.sram_ce), 32'd0);
    rst = 1'b0;
    #2;
    chk("rst_state", {bus.cmd_ready, bus.busy, bus.done, bus.rd_valid, bus.wr_ready, bus.sram_ce, bus.sram_we},
        7'b1000000);
    chk("rst_a", 32'(bus.sram_a), 32'd0);
    chk("rst_d", bus.sram_d, 32'd0);
    chk("rst_wem", bus.sram_wem, 32'd0);
    for (int i = 0; i < 18; i++) begin
      logic [80:0] act, exp;
      @(negedge clk);
      bus.cmd_valid = tbl[i].cv; bus.cmd_write = tbl[i].cw; bus.cmd_addr = tbl[i].ca;
      bus.cmd_len = tbl[i].cl; bus.wr_valid = tbl[i].wv; bus.wr_data = tbl[i].wd;
      #2;
      act = {bus.cmd_ready, bus.wr_ready, bus.busy, bus.done, bus.sram_ce, bus.sram_we,
             bus.sram_a, bus.sram_d, bus.sram_wem, bus.rd_valid};
      exp = {tbl[i].flags, tbl[i].a, tbl[i].d, tbl[i].flags[0] ? 32'hFFFF_FFFF : 32'h0, 1'b0};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL vec%0d: got %h, expected %h", i, act, exp);
      end
    end
    bus.cmd_valid = 1'b0; bus.wr_valid = 1'b0;
    exp_q[0] = 32'hA0; exp_q[1] = 32'hA1; exp_q[2] = 32'hA2; exp_q[3] = 32'hA3;
    run_read(10'h3F0, 4, 6'b111111, 3);
    exp_q[0] = 32'hB0; exp_q[1] = 32'hB1; exp_q[2] = 32'hB2; exp_q[3] = 32'hB3;
    exp_q[4] = 32'h5500_0002; exp_q[5] = 32'h5500_0003;
    run_read(10'h3FE, 6, 6'b101001, -1);
    run_read(10'h3FE, 4, 6'b111111, 3);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 10'h3F0; bus.cmd_len = 11'd6;
    bus.rd_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
    #2;
    chk("full_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("full_no_issue", 32'(bus.sram_ce), 32'd0);
    chk("full_busy", 32'(bus.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_outputs", {bus.rd_valid, bus.sram_ce, bus.busy, bus.done}, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      chk("post_rst_quiet", {bus.done, bus.sram_ce, bus.cmd_ready, bus.busy}, 4'b0010);
      @(negedge clk);
    end
    exp_q[0] = 32'hA0; exp_q[1] = 32'hA1; exp_q[2] = 32'hA2; exp_q[3] = 32'hA3;
    run_read(10'h3F0, 4, 6'b111111, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
